// File: rtl/caf_pkg.sv
// caf_pkg: shared constants and helpers for the CAF datapath stages
package caf_pkg;
  localparam int CAF_FRAME_CNT_BITS = 16;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/cpx_accumulate.sv
// cpx_accumulate: sums ACC_LEN consecutive complex products into one complex frame result
module cpx_accumulate import caf_pkg::*; #(
  parameter int I_BITS     = 24,
  parameter int Q_BITS     = 24,
  parameter int ACC_LEN    = 32,
  parameter int I_OUT_BITS = I_BITS + clog2(ACC_LEN),
  parameter int Q_OUT_BITS = Q_BITS + clog2(ACC_LEN)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic signed [I_BITS-1:0]            i_in,
  input  logic signed [Q_BITS-1:0]            q_in,
  input  logic                                in_valid,
  input  logic                                clear,
  output logic signed [I_OUT_BITS-1:0]        i_out,
  output logic signed [Q_OUT_BITS-1:0]        q_out,
  output logic                                out_valid,
  output logic [CAF_FRAME_CNT_BITS-1:0]       frame_cnt
);
  localparam int CW = clog2(ACC_LEN);
  localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);
  logic [CW-1:0] cnt;
  logic signed [I_OUT_BITS-1:0] acc_i, sum_i;
  logic signed [Q_OUT_BITS-1:0] acc_q, sum_q;
  logic last;
  assign sum_i = acc_i + {{(I_OUT_BITS-I_BITS){i_in[I_BITS-1]}}, i_in};
  assign sum_q = acc_q + {{(Q_OUT_BITS-Q_BITS){q_in[Q_BITS-1]}}, q_in};
  assign last  = in_valid && cnt == LAST;
  // clear has priority over in_valid, so a cleared last sample never emits a frame
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_i     <= '0;
      acc_q     <= '0;
      cnt       <= '0;
      i_out     <= '0;
      q_out     <= '0;
      out_valid <= 1'b0;
      frame_cnt <= '0;
    end else begin
      out_valid <= 1'b0;
      if (clear) begin
        acc_i <= '0;
        acc_q <= '0;
        cnt   <= '0;
      end else if (last) begin
        i_out     <= sum_i;
        q_out     <= sum_q;
        out_valid <= 1'b1;
        frame_cnt <= frame_cnt + 1'b1;
        acc_i     <= '0;
        acc_q     <= '0;
        cnt       <= '0;
      end else if (in_valid) begin
        acc_i <= sum_i;
        acc_q <= sum_q;
        cnt   <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cpx_accumulate.sv
// tb_cpx_accumulate: directed checks on an ACC_LEN=4 and an ACC_LEN=32 instance
module tb_cpx_accumulate;
  logic clk = 1'b0;
  logic reset, clear, v4, v32;
  logic signed [23:0] i_in, q_in;
  logic signed [25:0] i4, q4;
  logic signed [28:0] i32, q32;
  logic ov4, ov32;
  logic [15:0] fc4, fc32;
  int checks = 0, errors = 0;
  longint si, sq;
  logic signed [23:0] a, b;

  always #5 clk = ~clk;

  cpx_accumulate #(.I_BITS(24), .Q_BITS(24), .ACC_LEN(4)) dut4 (
    .clk(clk), .reset(reset), .i_in(i_in), .q_in(q_in), .in_valid(v4), .clear(clear),
    .i_out(i4), .q_out(q4), .out_valid(ov4), .frame_cnt(fc4));
  cpx_accumulate #(.I_BITS(24), .Q_BITS(24), .ACC_LEN(32)) dut32 (
    .clk(clk), .reset(reset), .i_in(i_in), .q_in(q_in), .in_valid(v32), .clear(clear),
    .i_out(i32), .q_out(q32), .out_valid(ov32), .frame_cnt(fc32));

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s4(input int i, input int q);
    i_in = 24'(i);
    q_in = 24'(q);
    v4 = 1'b1;
    tick();
    v4 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; v4 = 1'b1; v32 = 1'b1; i_in = 24'sd5; q_in = 24'sd5;
    repeat (3) tick();
    chk("rst_i", i4, 0);
    chk("rst_q", q4, 0);
    chk("rst_ov", ov4, 0);
    chk("rst_fc", fc4, 0);
    chk("rst_ov32", ov32, 0);
    reset = 1'b0; v4 = 1'b0; v32 = 1'b0;
    tick();
    chk("post_rst_ov", ov4, 0);
    s4(1, -1); s4(2, -2); s4(3, -3);
    chk("basic_no_early", ov4, 0);
    s4(4, -4);
    chk("basic_ov", ov4, 1);
    chk("basic_i", i4, 10);
    chk("basic_q", q4, -10);
    chk("basic_fc", fc4, 1);
    tick();
    chk("basic_pulse_1clk", ov4, 0);
    chk("basic_hold_i", i4, 10);
    i_in = -24'sd8388608; q_in = 24'sd8388607; v32 = 1'b1;
    repeat (31) tick();
    chk("ext_no_early", ov32, 0);
    tick();
    v32 = 1'b0;
    chk("ext_ov", ov32, 1);
    chk("ext_min_i", i32, -268435456);
    chk("ext_max_q", q32, 268435424);
    i_in = 24'sd8388607; v32 = 1'b1;
    repeat (32) tick();
    v32 = 1'b0;
    chk("ext_max_i", i32, 268435424);
    chk("ext_fc", fc32, 2);
    for (int k = 0; k < 4; k++) begin
      s4(5, 0);
      if (k < 3) for (int g = 0; g < 3; g++) begin
        tick();
        chk("gap_ov_low", ov4, 0);
      end
    end
    chk("gap_ov", ov4, 1);
    chk("gap_i", i4, 20);
    chk("gap_fc", fc4, 2);
    s4(7, 7); s4(7, 7);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_ov", ov4, 0);
    chk("clr_hold_i", i4, 20);
    chk("clr_hold_fc", fc4, 2);
    s4(1, 1); s4(1, 1); s4(1, 1);
    chk("clr_no_early", ov4, 0);
    s4(1, 1);
    chk("clr_ov2", ov4, 1);
    chk("clr_i", i4, 4);
    chk("clr_fc", fc4, 3);
    s4(1, 1); s4(1, 1); s4(1, 1);
    clear = 1'b1;
    s4(1, 1);
    clear = 1'b0;
    chk("clrlast_no_pulse", ov4, 0);
    chk("clrlast_hold_i", i4, 4);
    chk("clrlast_fc", fc4, 3);
    s4(2, 3); s4(2, 3); s4(2, 3); s4(2, 3);
    chk("after_clr_i", i4, 8);
    chk("after_clr_q", q4, 12);
    chk("after_clr_fc", fc4, 4);
    v4 = 1'b1;
    for (int f = 0; f < 20; f++) begin
      si = 0; sq = 0;
      for (int k = 0; k < 4; k++) begin
        a = 24'($urandom);
        b = 24'($urandom);
        si += a;
        sq += b;
        i_in = a;
        q_in = b;
        tick();
        if (k < 3) chk("stream_ov_low", ov4, 0);
      end
      chk("stream_ov", ov4, 1);
      chk("stream_i", i4, si);
      chk("stream_q", q4, sq);
    end
    v4 = 1'b0;
    tick();
    chk("stream_fc", fc4, 24);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
